// File: rtl/adc_spi_master.sv
`default_nettype none
// ============================================================================
// adc_spi_master : 24-bit SPI mode-0 frame engine (8-bit addr + 16-bit data)
//                  for the ADC configuration port; define ADC_SPI_3WIRE_EN to
//                  add spi_sdio_oe for a shared 3-wire SDIO pin.
// Revision 1.0
// ============================================================================
module adc_spi_master #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int GAP      = 4
) (
   input  logic        clk,
   input  logic        sys_rst_n,
   input  logic [7:0]  reg_addr,
   input  logic [15:0] wr_data,
   input  logic        start,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic        idle,
   output logic        spi_sclk,
   output logic        spi_mosi,
   output logic        spi_csn,
   input  logic        spi_miso
`ifdef ADC_SPI_3WIRE_EN
   ,
   output logic        spi_sdio_oe
`endif
);

   localparam int c_CNT_W = 16;
   localparam logic [c_CNT_W-1:0] c_ONE        = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP - 1);
   localparam logic [c_CNT_W-1:0] c_RISE_AT    = c_CNT_W'(CLK_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_BIT_LAST   = c_CNT_W'(2 * CLK_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD - 1);
   localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP - 1);
   localparam logic [4:0]         c_LAST_BIT   = 5'd23;
   localparam logic [4:0]         c_ADDR_LAST  = 5'd7;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_HOLD  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t               r_state, w_state;
   logic [c_CNT_W-1:0]   r_cnt, w_cnt;
   logic [4:0]           r_bit, w_bit;
   // Holds the 23 bits still to be sent; the bit on the wire lives in r_mosi.
   logic [22:0]          r_shift, w_shift;
   logic                 r_rw, w_rw;
   logic [15:0]          r_cap, w_cap;
   logic [15:0]          r_rd_data, w_rd_data;
   logic                 r_rd_valid, w_rd_valid;
   logic                 r_idle, w_idle;
   logic                 r_sclk, w_sclk;
   logic                 r_mosi, w_mosi;
   logic                 r_csn, w_csn;
`ifdef ADC_SPI_3WIRE_EN
   logic                 r_oe, w_oe;
`endif

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt + c_ONE;
      w_bit      = r_bit;
      w_shift    = r_shift;
      w_rw       = r_rw;
      w_cap      = r_cap;
      w_rd_data  = r_rd_data;
      w_rd_valid = 1'b0;
      w_idle     = r_idle;
      w_sclk     = r_sclk;
      w_mosi     = r_mosi;
      w_csn      = r_csn;
`ifdef ADC_SPI_3WIRE_EN
      w_oe       = r_oe;
`endif

      case (r_state)
         S_IDLE: begin
            w_cnt = '0;
            if (start) begin
               w_shift = {reg_addr[6:0], (reg_addr[7] ? wr_data : 16'h0000)};
               w_rw    = reg_addr[7];
               w_mosi  = reg_addr[7];
               w_idle  = 1'b0;
               w_csn   = 1'b0;
               w_sclk  = 1'b0;
               w_bit   = '0;
               w_state = S_SETUP;
`ifdef ADC_SPI_3WIRE_EN
               w_oe    = 1'b1;
`endif
            end
         end

         S_SETUP: begin
            if (r_cnt == c_SETUP_LAST) begin
               w_cnt   = '0;
               w_bit   = '0;
               w_state = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (r_cnt == c_RISE_AT) begin
               w_sclk = 1'b1;
               w_cap  = {r_cap[14:0], spi_miso};
            end
            if (r_cnt == c_BIT_LAST) begin
               // Falling edge: the only place MOSI is allowed to move.
               w_sclk  = 1'b0;
               w_cnt   = '0;
               w_mosi  = r_shift[22];
               w_shift = {r_shift[21:0], 1'b0};
`ifdef ADC_SPI_3WIRE_EN
               if ((r_bit == c_ADDR_LAST) && !r_rw) begin
                  w_oe = 1'b0;
               end
`endif
               if (r_bit == c_LAST_BIT) begin
                  w_state = S_HOLD;
               end else begin
                  w_bit = r_bit + 5'd1;
               end
            end
         end

         S_HOLD: begin
            if (r_cnt == c_HOLD_LAST) begin
               w_cnt   = '0;
               w_csn   = 1'b1;
               w_state = S_GAP;
`ifdef ADC_SPI_3WIRE_EN
               w_oe    = 1'b0;
`endif
               if (!r_rw) begin
                  w_rd_data  = r_cap;
                  w_rd_valid = 1'b1;
               end
            end
         end

         S_GAP: begin
            if (r_cnt == c_GAP_LAST) begin
               w_cnt   = '0;
               w_idle  = 1'b1;
               w_state = S_IDLE;
            end
         end

         default: begin
            w_cnt   = '0;
            w_idle  = 1'b1;
            w_csn   = 1'b1;
            w_sclk  = 1'b0;
            w_state = S_IDLE;
`ifdef ADC_SPI_3WIRE_EN
            w_oe    = 1'b0;
`endif
         end
      endcase
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cnt      <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_rw       <= 1'b0;
         r_cap      <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_idle     <= 1'b1;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_csn      <= 1'b1;
`ifdef ADC_SPI_3WIRE_EN
         r_oe       <= 1'b0;
`endif
      end else begin
         r_cnt      <= w_cnt;
         r_bit      <= w_bit;
         r_shift    <= w_shift;
         r_rw       <= w_rw;
         r_cap      <= w_cap;
         r_rd_data  <= w_rd_data;
         r_rd_valid <= w_rd_valid;
         r_idle     <= w_idle;
         r_sclk     <= w_sclk;
         r_mosi     <= w_mosi;
         r_csn      <= w_csn;
`ifdef ADC_SPI_3WIRE_EN
         r_oe       <= w_oe;
`endif
      end
   end

   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign idle     = r_idle;
   assign spi_sclk = r_sclk;
   assign spi_mosi = r_mosi;
   assign spi_csn  = r_csn;
`ifdef ADC_SPI_3WIRE_EN
   assign spi_sdio_oe = r_oe;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_master.sv
`default_nettype none
// ============================================================================
// tb_adc_spi_master : scoreboard bench for adc_spi_master with an SPI slave
//                     model; a second instance covers the minimum timing set.
// Revision 1.0
// ============================================================================
module tb_adc_spi_master;

   localparam int CLK_DIV   = 4;
   localparam int CS_SETUP  = 2;
   localparam int CS_HOLD   = 2;
   localparam int GAP       = 4;
   localparam int CSN_LOW   = CS_SETUP + 48 * CLK_DIV + CS_HOLD;
   localparam int FRAME_LEN = 1 + CSN_LOW + GAP;
   localparam int MIN_LEN   = 1 + 1 + 48 * 1 + 1 + 1;

   logic        clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [7:0]  reg_addr = '0;
   logic [15:0] wr_data = '0;
   logic        start = 1'b0;
   logic [15:0] rd_data;
   logic        rd_valid, idle, spi_sclk, spi_mosi, spi_csn;
   logic        spi_miso = 1'b0;

   logic [7:0]  reg_addr2 = '0;
   logic [15:0] wr_data2 = '0;
   logic        start2 = 1'b0;
   logic [15:0] rd_data2;
   logic        rd_valid2, idle2, sclk2, mosi2, csn2;
   logic        miso2 = 1'b0;
`ifdef ADC_SPI_3WIRE_EN
   logic        spi_sdio_oe, oe2;
`endif

   always #5 clk = ~clk;

   adc_spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .GAP(GAP)) dut (
      .clk(clk), .sys_rst_n(sys_rst_n), .reg_addr(reg_addr), .wr_data(wr_data), .start(start),
      .rd_data(rd_data), .rd_valid(rd_valid), .idle(idle), .spi_sclk(spi_sclk),
      .spi_mosi(spi_mosi), .spi_csn(spi_csn), .spi_miso(spi_miso)
`ifdef ADC_SPI_3WIRE_EN
      , .spi_sdio_oe(spi_sdio_oe)
`endif
   );

   adc_spi_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .GAP(1)) dut_min (
      .clk(clk), .sys_rst_n(sys_rst_n), .reg_addr(reg_addr2), .wr_data(wr_data2), .start(start2),
      .rd_data(rd_data2), .rd_valid(rd_valid2), .idle(idle2), .spi_sclk(sclk2),
      .spi_mosi(mosi2), .spi_csn(csn2), .spi_miso(miso2)
`ifdef ADC_SPI_3WIRE_EN
      , .spi_sdio_oe(oe2)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: the frame is address then data (zeros for a read); a read returns the slave word.
   typedef struct {
      logic [23:0] bits;
      logic        rw;
      logic [15:0] miso;
   } exp_t;

   exp_t sb[$];
   int   n_push  = 0;
   int   n_abort = 0;

   function automatic exp_t model(input logic [7:0] a, input logic [15:0] d, input logic [15:0] m);
      exp_t e;
      e.rw   = a[7];
      e.bits = {a, (a[7] ? d : 16'h0000)};
      e.miso = m;
      return e;
   endfunction

   // ---------------- monitor / slave model ----------------
   exp_t        m_cur;
   logic        m_have = 1'b0, m_in = 1'b0, m_oe_err = 1'b0, m_gap_valid = 1'b0, m_end;
   logic        p_csn = 1'b1, p_sclk = 1'b0, p_idle = 1'b1;
   int          m_low = 0, m_nbits = 0, m_high = 0, m_idle_run = 0, m_frames = 0;
   logic [23:0] m_bits = '0;
   logic [15:0] m_last_rd = '0;

   always @(negedge clk) begin
      if (!sys_rst_n) begin
         m_in        = 1'b0;
         m_gap_valid = 1'b0;
         m_idle_run  = 0;
         m_last_rd   = '0;
         sb.delete();
      end else begin
         m_end = m_in && !p_csn && spi_csn;
         if (!idle) begin
            m_idle_run++;
         end else if (!p_idle) begin
            check("frame_len", m_idle_run + 1, FRAME_LEN);
            m_idle_run = 0;
         end
         if (rd_valid && !m_end) check("stray_rd_valid", rd_valid, 1'b0);

         if (p_csn && !spi_csn) begin
            if (m_gap_valid) check("csn_high_gap_ok", m_high >= GAP + 1, 1'b1);
            if (sb.size() == 0) begin
               check("unexpected_frame", 1, 0);
               m_have = 1'b0;
            end else begin
               m_cur  = sb.pop_front();
               m_have = 1'b1;
            end
            m_in = 1'b1; m_low = 0; m_nbits = 0; m_bits = '0; m_oe_err = 1'b0;
         end

         if (m_in && !spi_csn) begin
            m_low++;
            if (spi_sclk && !p_sclk) begin
               m_bits = {m_bits[22:0], spi_mosi};
               m_nbits++;
            end
`ifdef ADC_SPI_3WIRE_EN
            if (m_have && (spi_sdio_oe !== (m_cur.rw || m_nbits < 8 || (m_nbits == 8 && spi_sclk))))
               m_oe_err = 1'b1;
`endif
            if (!spi_sclk && m_nbits < 24) begin
               if (m_nbits < 8) spi_miso = 1'($urandom_range(0, 1));
               else             spi_miso = m_cur.miso[23 - m_nbits];
            end
         end

         if (m_end) begin
            if (m_have) begin
               check("csn_low_cycles", m_low, CSN_LOW);
               check("sclk_rises", m_nbits, 24);
               check("mosi_frame", m_bits, m_cur.bits);
               check("rd_valid_at_gap", rd_valid, !m_cur.rw);
               if (!m_cur.rw) m_last_rd = m_cur.miso;
               check("rd_data", rd_data, m_last_rd);
`ifdef ADC_SPI_3WIRE_EN
               if (spi_sdio_oe) m_oe_err = 1'b1;
               check("sdio_oe_profile", m_oe_err, 1'b0);
`endif
               m_frames++;
            end
            m_in = 1'b0; m_high = 1; m_gap_valid = 1'b1;
         end else if (spi_csn) begin
            m_high++;
         end
      end
      p_csn = spi_csn; p_sclk = spi_sclk; p_idle = idle;
   end

   // ---------------- stimulus ----------------
   task automatic wait_idle();
      int n = 0;
      while (!idle && n < 2 * FRAME_LEN) begin
         @(posedge clk); #1;
         n++;
      end
      if (!idle) check("idle_timeout", 0, 1);
   endtask

   task automatic issue(input logic [7:0] a, input logic [15:0] d, input logic [15:0] m);
      wait_idle();
      reg_addr = a;
      wr_data  = d;
      sb.push_back(model(a, d, m));
      n_push++;
      start = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      reg_addr = 8'($urandom);
      wr_data  = 16'($urandom);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int          k2, n2, off_at;
      logic        p2, off_sclk, done;
      logic [23:0] bits2;
      int          v2;

      repeat (2) @(posedge clk); #1;
      check("rst_idle", idle, 1'b1);
      check("rst_csn", spi_csn, 1'b1);
      check("rst_sclk", spi_sclk, 1'b0);
      check("rst_mosi", spi_mosi, 1'b0);
      check("rst_rd_data", rd_data, 16'h0);
      check("rst_rd_valid", rd_valid, 1'b0);
      @(posedge clk); #1;
      sys_rst_n = 1'b1;
      @(posedge clk); #1;

      issue(8'h81, 16'h0008, 16'hFFFF);
      issue(8'h11, 16'h1234, 16'hA5C3);

      issue(8'h3C, 16'h0000, 16'($urandom));
      repeat (49) @(posedge clk); #1;
      reg_addr = 8'hA0; wr_data = 16'h0200; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;

      wait_idle();
      reg_addr = 8'h9C; wr_data = 16'h5A5A; start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_idle();
         sb.push_back(model(8'h9C, 16'h5A5A, 16'($urandom)));
         n_push++;
         @(posedge clk); #1;
      end
      start = 1'b0;

      for (int i = 0; i < 8; i++) begin
         issue(8'($urandom), 16'($urandom), 16'($urandom));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #0;
      end

      issue({1'b0, 7'($urandom)}, 16'($urandom), 16'($urandom));
      repeat (99) @(posedge clk); #1;
      sys_rst_n = 1'b0;
      #1;
      check("abort_csn", spi_csn, 1'b1);
      check("abort_sclk", spi_sclk, 1'b0);
      check("abort_idle", idle, 1'b1);
      check("abort_rd_valid", rd_valid, 1'b0);
      check("abort_rd_data", rd_data, 16'h0);
      @(posedge clk); #1;
      sys_rst_n = 1'b1;
      n_abort++;
      @(posedge clk); #1;
      issue(8'h11, 16'h0000, 16'($urandom));
      wait_idle();
      repeat (3) @(posedge clk); #1;

      check("scoreboard_empty", sb.size(), 0);
      check("frames_completed", m_frames, n_push - n_abort);

      // Minimum-timing instance: write 0x8F/0x0003.
      reg_addr2 = 8'h8F; wr_data2 = 16'h0003; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      k2 = 0; p2 = 1'b0; bits2 = '0; done = 1'b0; v2 = 0;
      while (!done && k2 < 200) begin
         @(negedge clk);
         k2++;
         if (sclk2 && !p2) bits2 = {bits2[22:0], mosi2};
         if (rd_valid2) v2++;
         p2 = sclk2;
         if (idle2) done = 1'b1;
      end
      check("min_frame_len", k2, MIN_LEN);
      check("min_mosi_frame", bits2, 24'h8F0003);
      check("min_no_rd_valid", v2, 0);
      check("min_rd_data_kept", rd_data2, 16'h0);
`ifdef ADC_SPI_3WIRE_EN
      @(posedge clk); #1;
      reg_addr2 = 8'h05; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      k2 = 0; n2 = 0; p2 = 1'b0; done = 1'b0; off_at = -1; off_sclk = 1'b1;
      while (!done && k2 < 200) begin
         @(negedge clk);
         k2++;
         if (k2 == 1) check("min_oe_on_at_start", oe2, 1'b1);
         if (sclk2 && !p2) n2++;
         p2 = sclk2;
         if (!csn2 && !oe2 && off_at < 0) begin
            off_at   = n2;
            off_sclk = sclk2;
         end
         if (idle2) done = 1'b1;
      end
      check("min_oe_off_after_bit8", off_at, 8);
      check("min_oe_off_on_fall", off_sclk, 1'b0);
      check("min_oe_low_when_idle", oe2, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
